sb_rr_arbiter: RTL and testbench

Shares one valid/ready sink, such as the fifo write port or the sink block, between N_SRC independent valid/ready sources. The arbiter grants one source at a time using round-robin order, with a bounded burst length per grant. The granted source's data and handshake pass through to the sink. It sits between the producer blocks and the fifo/sink in the fifo test system.

---
 rtl/sb_arb_pkg.sv | 35 +++
 rtl/rr_pick.sv | 46 ++++
 rtl/sb_rr_arbiter_chk.sv | 26 ++
 rtl/sb_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_sb_rr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_arb_pkg.sv
// -----------------------------------------------------------------------------
// sb_arb_pkg
// Shared definitions for the source-to-sink round-robin arbiter:
//   arb_state_t    - arbiter state (IDLE between grants, GRANT while serving)
//   DEF_DATA_W     - default payload width
//   MAX_SRC        - largest supported source count
//   MAX_IDX_W      - index width that covers MAX_SRC sources
//   onehot_to_idx  - converts a one-hot vector (up to MAX_SRC wide) to an index
// -----------------------------------------------------------------------------
package sb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int MAX_SRC    = 16;
  localparam int MAX_IDX_W  = 4;

  // OR of the indices of all set bits; exact for a one-hot or all-zero vector.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_SRC-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = 0; i < MAX_SRC; i++) begin
      if (vec[i]) begin
        idx = idx | MAX_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage : sb_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts at the entry
// just after last_ptr and wraps modulo N, so the most recently served index
// has the lowest priority.
// Ports:
//   req        [N]   request vector
//   last_ptr   [IW]  index served most recently
//   gnt_onehot [N]   one-hot winner, zero when no request
//   gnt_idx    [IW]  winner index, zero when no request
//   any        [1]   at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import sb_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] pos_s;

  // Walk the requests in rotated order; the first hit wins.
  always_comb begin
    gnt_onehot = {N{1'b0}};
    any        = 1'b0;
    pos_s      = {IW{1'b0}};
    for (int i = 1; i <= N; i++) begin
      pos_s = IW'((int'(last_ptr) + i) % N);
      if (!any && req[pos_s]) begin
        gnt_onehot[pos_s] = 1'b1;
        any               = 1'b1;
      end else begin
        any = any;
      end
    end
  end

  assign gnt_idx = IW'(onehot_to_idx(MAX_SRC'(gnt_onehot)));

endmodule : rr_pick

// File: rtl/sb_rr_arbiter_chk.sv
// -----------------------------------------------------------------------------
// sb_rr_arbiter_chk
// Invariant checker for sb_rr_arbiter's internal state.
// Ports:
//   clk_i, rstn_i    clock and synchronous active-low reset
//   grant [N_SRC]    registered one-hot grant
//   busy             registered GRANT-state flag
//   burst_cnt [CW]   transfers already made in the current grant
// -----------------------------------------------------------------------------
module sb_rr_arbiter_chk #(
  parameter int N_SRC     = 4,
  parameter int BURST_MAX = 4,
  parameter int CW        = 3
) (
  input logic             clk_i,
  input logic             rstn_i,
  input logic [N_SRC-1:0] grant,
  input logic             busy,
  input logic [CW-1:0]    burst_cnt
);

  grant_onehot0_a : assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(grant));
  busy_grant_a    : assert property (@(posedge clk_i) disable iff (!rstn_i) busy == (|grant));
  cnt_bound_a     : assert property (@(posedge clk_i) disable iff (!rstn_i) int'(burst_cnt) < BURST_MAX);

endmodule : sb_rr_arbiter_chk

// File: rtl/sb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sb_rr_arbiter
// Shares one valid/ready sink between N_SRC valid/ready sources. One source is
// granted at a time in round-robin order for at most BURST_MAX transfers; the
// granted source's handshake and data pass straight through. One idle cycle
// always separates two grants. No data is buffered.
// Ports:
//   clk_i      [1]             clock, all state on rising edge
//   rstn_i     [1]             synchronous active-low reset
//   s_valid_i  [N_SRC]         per-source valid
//   s_data_i   [N_SRC*DATA_W]  per-source data, source k at [k*DATA_W +: DATA_W]
//   s_ready_o  [N_SRC]         per-source ready
//   m_valid_o  [1]             valid to sink
//   m_data_o   [DATA_W]        data to sink
//   m_ready_i  [1]             ready from sink
//   grant_o    [N_SRC]         one-hot current grant, zero when idle
//   busy_o     [1]             high while a source is granted
// -----------------------------------------------------------------------------
module sb_rr_arbiter
  import sb_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [N_SRC-1:0]        s_valid_i,
  input  logic [N_SRC*DATA_W-1:0] s_data_i,
  output logic [N_SRC-1:0]        s_ready_o,
  output logic                    m_valid_o,
  output logic [DATA_W-1:0]       m_data_o,
  input  logic                    m_ready_i,
  output logic [N_SRC-1:0]        grant_o,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);
  localparam logic [IDX_W-1:0] RST_PTR  = IDX_W'(N_SRC - 1);

  arb_state_t         state_r;
  logic [N_SRC-1:0]   grant_r;
  logic [IDX_W-1:0]   g_idx_r;
  logic [IDX_W-1:0]   last_ptr_r;
  logic [CNT_W-1:0]   burst_cnt_r;
  logic               busy_r;

  logic [N_SRC-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               m_valid_s;
  logic [DATA_W-1:0]  m_data_s;
  logic [N_SRC-1:0]   s_ready_s;
  logic               xfer_s;

  rr_pick #(
    .N (N_SRC)
  ) u_pick (
    .req        (s_valid_i),
    .last_ptr   (last_ptr_r),
    .gnt_onehot (pick_onehot_s),
    .gnt_idx    (pick_idx_s),
    .any        (pick_any_s)
  );

  // Pass-through of the granted source; grant_r is all-zero in IDLE, which
  // forces every sink-side and ready output to zero there.
  always_comb begin
    m_valid_s = 1'b0;
    m_data_s  = {DATA_W{1'b0}};
    s_ready_s = {N_SRC{1'b0}};
    if (state_r == GRANT) begin
      m_valid_s = |(s_valid_i & grant_r);
      s_ready_s = grant_r & {N_SRC{m_ready_i}};
      for (int k = 0; k < N_SRC; k++) begin
        m_data_s = m_data_s | (s_data_i[k*DATA_W +: DATA_W] & {DATA_W{grant_r[k]}});
      end
    end else begin
      m_valid_s = 1'b0;
    end
  end

  assign xfer_s = m_valid_s & m_ready_i;

  // Grant/release sequencing, burst counting and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r     <= IDLE;
      grant_r     <= {N_SRC{1'b0}};
      g_idx_r     <= {IDX_W{1'b0}};
      last_ptr_r  <= RST_PTR;
      burst_cnt_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            state_r     <= GRANT;
            grant_r     <= pick_onehot_s;
            g_idx_r     <= pick_idx_s;
            burst_cnt_r <= {CNT_W{1'b0}};
            busy_r      <= 1'b1;
          end
        end
        GRANT: begin
          // A dropped valid releases without a transfer; a full burst
          // releases on its last transfer.
          if (!m_valid_s || (xfer_s && (burst_cnt_r == LAST_CNT))) begin
            state_r     <= IDLE;
            grant_r     <= {N_SRC{1'b0}};
            last_ptr_r  <= g_idx_r;
            burst_cnt_r <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
          end else if (xfer_s) begin
            burst_cnt_r <= burst_cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_r     <= IDLE;
          grant_r     <= {N_SRC{1'b0}};
          burst_cnt_r <= {CNT_W{1'b0}};
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid_o = m_valid_s;
  assign m_data_o  = m_data_s;
  assign s_ready_o = s_ready_s;
  assign grant_o   = grant_r;
  assign busy_o    = busy_r;

  sb_rr_arbiter_chk #(
    .N_SRC     (N_SRC),
    .BURST_MAX (BURST_MAX),
    .CW        (CNT_W)
  ) u_chk (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .grant     (grant_r),
    .busy      (busy_r),
    .burst_cnt (burst_cnt_r)
  );

endmodule : sb_rr_arbiter

// File: tb/tb_sb_rr_arbiter.sv
module tb_sb_rr_arbiter;

  localparam int N  = 4;
  localparam int BM = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 4 sources, burst 4.
  logic        rstn;
  logic [3:0]  s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [3:0]  grant;
  logic        busy;

  // Second instance: 2 sources, burst 1 (word-level round-robin).
  logic [1:0]  s_valid1;
  logic [15:0] s_data1;
  logic [1:0]  s_ready1;
  logic        m_valid1;
  logic [7:0]  m_data1;
  logic        m_ready1;
  logic [1:0]  grant1;
  logic        busy1;

  sb_rr_arbiter #(.N_SRC(4), .DATA_W(8), .BURST_MAX(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(s_ready), .m_valid_o(m_valid), .m_data_o(m_data),
    .m_ready_i(m_ready), .grant_o(grant), .busy_o(busy));

  sb_rr_arbiter #(.N_SRC(2), .DATA_W(8), .BURST_MAX(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid1), .s_data_i(s_data1),
    .s_ready_o(s_ready1), .m_valid_o(m_valid1), .m_data_o(m_data1),
    .m_ready_i(m_ready1), .grant_o(grant1), .busy_o(busy1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: who holds the sink (-1 = nobody), transfers done, last served.
  int m_owner = -1;
  int m_done  = 0;
  int m_last  = N - 1;

  task automatic model_update();
    if (!rstn) begin
      m_owner = -1; m_done = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && s_valid[2'(c)]) begin
          m_owner = c; m_done = 0;
        end
      end
    end else if (!s_valid[2'(m_owner)]) begin
      m_last = m_owner; m_owner = -1;
    end else if (m_ready) begin
      m_done++;
      if (m_done == BM) begin
        m_last = m_owner; m_owner = -1;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] eg, esr;
    logic       emv, eb;
    logic [7:0] ed;
    eg = 4'b0000; esr = 4'b0000; emv = 1'b0; eb = 1'b0; ed = 8'h00;
    if (m_owner >= 0) begin
      eg  = 4'b0001 << m_owner;
      eb  = 1'b1;
      emv = s_valid[2'(m_owner)];
      ed  = 8'(s_data >> (m_owner * 8));
      esr = m_ready ? eg : 4'b0000;
    end
    chk({tag, "_grant"},   32'(grant),   32'(eg));
    chk({tag, "_busy"},    32'(busy),    32'(eb));
    chk({tag, "_m_valid"}, 32'(m_valid), 32'(emv));
    chk({tag, "_m_data"},  32'(m_data),  32'(ed));
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(esr));
  endtask

  // Finish the current cycle: advance the model across the edge, then step past it.
  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_valid = 4'h0; s_valid1 = 2'b00;
    @(negedge clk);
    adv();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        rstn;
    logic [3:0]  sv;
    logic        mr;
    logic [31:0] sd;
    logic        do_chk;
    logic [3:0]  eg;
    logic        emv;
    logic [3:0]  esr;
    logic [7:0]  ed;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] sv, input logic mr, input logic [31:0] sd,
                     input logic c, input logic [3:0] eg, input logic emv, input logic [3:0] esr,
                     input logic [7:0] ed, input logic eb);
    vec_t v;
    v.rstn = r; v.sv = sv; v.mr = mr; v.sd = sd; v.do_chk = c;
    v.eg = eg; v.emv = emv; v.esr = esr; v.ed = ed; v.eb = eb;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit          found;
    int          xf;
    int          x_src;
    int          exp_src;
    bit          prev_x;
    logic [3:0]  gbit;
    logic [7:0]  dbit;

    rstn = 1'b0; s_valid = 4'h0; s_data = 32'h0; m_ready = 1'b1;
    s_valid1 = 2'b00; s_data1 = 16'h0; m_ready1 = 1'b1;
    @(negedge clk);
    adv();

    // ---- Table: test 1 (single requester) and test 2 (all four busy) ----
    add(1'b0, 4'h0, 1'b1, 32'h000000A5, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0);
    add(1'b1, 4'h1, 1'b1, 32'h000000A5, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0);
    for (int j = 0; j < 4; j++)
      add(1'b1, 4'h1, 1'b1, 32'h000000A5, 1'b1, 4'h1, 1'b1, 4'h1, 8'hA5, 1'b1);
    add(1'b1, 4'h1, 1'b1, 32'h000000A5, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0);
    add(1'b1, 4'h1, 1'b1, 32'h000000A5, 1'b1, 4'h1, 1'b1, 4'h1, 8'hA5, 1'b1);

    add(1'b0, 4'h0, 1'b1, 32'h13121110, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      add(1'b1, 4'hF, 1'b1, 32'h13121110, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0);
      gbit = 4'b0001 << (k % 4);
      dbit = 8'h10 + 8'(k % 4);
      for (int j = 0; j < ((k < 4) ? 4 : 1); j++)
        add(1'b1, 4'hF, 1'b1, 32'h13121110, 1'b1, gbit, 1'b1, gbit, dbit, 1'b1);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      rstn = tbl[i].rstn; s_valid = tbl[i].sv; m_ready = tbl[i].mr; s_data = tbl[i].sd;
      @(negedge clk);
      if (tbl[i].do_chk) begin
        chk($sformatf("v%0d_grant", i),   32'(grant),   32'(tbl[i].eg));
        chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].emv));
        chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].esr));
        chk($sformatf("v%0d_m_data", i),  32'(m_data),  32'(tbl[i].ed));
        chk($sformatf("v%0d_busy", i),    32'(busy),    32'(tbl[i].eb));
      end
      adv();
    end
    rstn = 1'b1;

    // ---- Test 3: source 2 drops valid mid-burst; 3 is next, not 0 ----
    do_reset();
    s_data = 32'h23222120; m_ready = 1'b1;
    s_valid = 4'b0010;
    @(negedge clk); adv();                        // IDLE -> grant 1
    s_valid = 4'b0000;
    @(negedge clk);
    chk("t3_g1", 32'(grant), 32'(4'b0010));
    adv();                                        // drop releases, last = 1
    s_valid = 4'b1101;
    @(negedge clk);
    chk("t3_idle", 32'(busy), 32'(0));
    adv();                                        // pick from 2 -> 2
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("t3_g2", 32'(grant), 32'(4'b0100));
      chk("t3_d2", 32'(m_data), 32'(8'h22));
      adv();
    end
    s_valid = 4'b1001;
    @(negedge clk);
    chk("t3_drop_grant", 32'(grant), 32'(4'b0100));
    chk("t3_drop_mvalid", 32'(m_valid), 32'(0));
    adv();
    @(negedge clk);
    chk("t3_bubble", 32'(grant), 32'(0));
    adv();
    @(negedge clk);
    chk("t3_next_g3", 32'(grant), 32'(4'b1000));
    adv();

    // ---- Test 4: sink stall mid-burst of source 1 ----
    do_reset();
    s_data = 32'h44434241; s_valid = 4'b0010; m_ready = 1'b1;
    @(negedge clk); adv();
    @(negedge clk);
    chk("t4_first", 32'(grant), 32'(4'b0010));
    adv();                                        // one transfer done
    m_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t4_stall_grant", 32'(grant), 32'(4'b0010));
      chk("t4_stall_mvalid", 32'(m_valid), 32'(1));
      chk("t4_stall_sready", 32'(s_ready), 32'(0));
      adv();
    end
    m_ready = 1'b1;
    xf = 0;
    found = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (busy && m_valid && m_ready) begin
        xf++;
        adv();
      end else begin
        found = 1'b1;
        break;
      end
    end
    if (!found) @(negedge clk);
    chk("t4_rest_xfers", 32'(xf), 32'(3));
    chk("t4_released", 32'(grant), 32'(0));
    adv();

    // ---- Test 5: reset during source 1 burst ----
    do_reset();
    s_data = 32'h55545352; s_valid = 4'hF; m_ready = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (grant == 4'b0010) begin
        found = 1'b1;
        break;
      end
      adv();
    end
    if (!found) @(negedge clk);
    chk("t5_reach_g1", 32'(found), 32'(1));
    adv();                                        // one transfer of source 1
    rstn = 1'b0;
    @(negedge clk); adv();
    rstn = 1'b1;
    @(negedge clk);
    chk("t5_rst_grant", 32'(grant), 32'(0));
    chk("t5_rst_busy", 32'(busy), 32'(0));
    chk("t5_rst_mvalid", 32'(m_valid), 32'(0));
    chk("t5_rst_sready", 32'(s_ready), 32'(0));
    chk("t5_rst_mdata", 32'(m_data), 32'(0));
    adv();
    @(negedge clk);
    chk("t5_regrant0", 32'(grant), 32'(4'b0001));
    adv();

    // ---- Random stimulus against the reference model ----
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rstn    = ($urandom_range(0, 49) != 0);
      s_valid = 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      @(negedge clk);
      model_check("rnd");
      adv();
    end
    rstn = 1'b1; s_valid = 4'h0;

    // ---- Test 6: BURST_MAX=1, two sources alternate ----
    do_reset();
    s_valid1 = 2'b11; m_ready1 = 1'b1; s_data1 = {8'h80, 8'h40};
    xf = 0; prev_x = 1'b0;
    for (int c = 0; c < 30 && xf < 6; c++) begin
      @(negedge clk);
      if (prev_x) chk("t6_bubble", 32'(grant1), 32'(0));
      prev_x = 1'b0;
      x_src = -1;
      if (m_valid1 && m_ready1) begin
        exp_src = xf % 2;
        chk("t6_grant", 32'(grant1), 32'(2'b01 << exp_src));
        chk("t6_data", 32'(m_data1),
            32'((exp_src == 0) ? (8'h40 + 8'(xf / 2)) : (8'h80 + 8'(xf / 2))));
        x_src = grant1[1] ? 1 : 0;
        xf++;
        prev_x = 1'b1;
      end
      adv();
      if (x_src == 0) s_data1[7:0] = s_data1[7:0] + 8'h01;
      else if (x_src == 1) s_data1[15:8] = s_data1[15:8] + 8'h01;
    end
    chk("t6_count", 32'(xf), 32'(6));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sb_rr_arbiter
